asrv32_writeback: RTL and testbench
===================================

Name: asrv32_writeback

Overview:
- Writeback stage driving the write side of the base register file: produces `o_ce_wr`, `o_rd_addr` and `o_rd_data` from completed instructions.
- Non-load results retire one cycle after acceptance.
- Loads wait for the data-memory acknowledge, then the returned word is byte/halfword aligned and sign/zero extended before the write.
- Back-pressures the memory stage through `o_stall` while a load is outstanding.

Parameters:
- LOAD_TIMEOUT, 0: max cycles spent in WAIT_LOAD before abort; 0 = wait forever.
- CNT_W, 8: width of the internal timeout counter; LOAD_TIMEOUT must be < 2^CNT_W.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst  in  1  reset; synchronous, active-high.
- i_ce  in  1  instruction from memory stage is valid this cycle.
- i_wr_rd  in  1  instruction writes rd.
- i_rd_addr  in  5  destination register index.
- i_is_load  in  1  instruction is a load.
- i_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_addr_lsb  in  2  byte offset of the load address.
- i_alu_result  in  32  result for non-load instructions.
- i_mem_ack  in  1  data memory read data valid.
- i_mem_rdata  in  32  data memory read word.
- o_stall  out  1  upstream must hold its outputs.
- o_ce_wr  out  1  register file write enable (1-cycle pulse).
- o_rd_addr  out  5  register file write address.
- o_rd_data  out  32  register file write data.
- o_load_fault  out  1  1-cycle pulse on load timeout.

Behaviour:
- Reset: state IDLE; timeout counter 0.
- Reset values: `o_ce_wr`=0, `o_rd_addr`=0, `o_rd_data`=0, `o_load_fault`=0.
- Reset mid-load: abandons the load with no write.
- All outputs are registered except `o_stall`, which is combinational:
  - `o_stall` = (state==WAIT_LOAD & !i_mem_ack) | (state==IDLE & i_ce & i_is_load & !i_mem_ack).
- IDLE, i_ce & !i_is_load:
  - next cycle `o_ce_wr` = i_wr_rd & (i_rd_addr!=0).
  - `o_rd_addr`/`o_rd_data` take i_rd_addr/i_alu_result. Latency 1.
- IDLE, i_ce & i_is_load & i_mem_ack: next cycle write of the aligned load data. Latency 1, no stall.
- IDLE, i_ce & i_is_load & !i_mem_ack:
  - capture rd_addr, wr_rd, funct3, addr_lsb.
  - clear counter; go to WAIT_LOAD.
- WAIT_LOAD:
  - i_ce is ignored; upstream holds its outputs stable.
  - On i_mem_ack: next cycle write with the captured fields; return to IDLE.
  - Otherwise the counter increments.
  - If LOAD_TIMEOUT!=0 and counter==LOAD_TIMEOUT-1 without ack: next cycle `o_load_fault`=1, no write, return to IDLE.
  - Ack and timeout in the same cycle: ack wins.
- i_mem_ack while in IDLE with no load presented: ignored.
- Alignment (applies to rdata):
  - LB/LBU: byte selected by lsb, then sign/zero extended.
  - LH/LHU: halfword [15:0] if lsb[1]==0, else [31:16]; lsb[0] ignored.
  - LW and undefined funct3: full word.
- Data hold: `o_rd_addr`/`o_rd_data` keep their last values when `o_ce_wr`=0.
- rd=x0: no write pulse ever (includes loads).
- Throughput: back-to-back non-load instructions produce one write per cycle.

Optional Feature:
- ASRV32_WB_FWD_EN defined: adds outputs `o_fwd_valid`(1), `o_fwd_addr`(5) and `o_fwd_data`(32).
  - They mirror `o_ce_wr`/`o_rd_addr`/`o_rd_data` in the same cycle, for a decode-stage bypass.
  - Additionally, `o_fwd_valid` is 0 when `o_ce_wr`=0.
  - Reset value 0.
- ASRV32_WB_FWD_EN undefined: these ports do not exist; behaviour is otherwise identical.

Test Plan:
- ALU write: i_ce=1, wr_rd=1, rd=5, alu=0x12345678 -> next cycle `o_ce_wr`=1, addr=5, data=0x12345678; the cycle after, `o_ce_wr`=0.
- x0 suppression: i_ce=1, rd=0, alu=0xFFFFFFFF -> `o_ce_wr` stays 0; same for a load to x0 with ack.
- LB with same-cycle ack: funct3=000, lsb=3, rdata=0x80FF_0000, rd=7 -> next cycle data=0xFFFFFF80. With LBU -> 0x00000080. LH lsb=2 -> 0xFFFF80FF.
- Stalled load: load rd=9, no ack for 3 cycles -> `o_stall`=1 for those 3 cycles, no write. Ack with rdata=0xDEADBEEF (LW) -> `o_stall`=0 that cycle, next cycle write rd=9, data=0xDEADBEEF.
- Timeout: LOAD_TIMEOUT=4, load with no ack -> fault pulse, state IDLE, no write, `o_stall` low afterwards. Ack on the final cycle instead -> normal write, no fault.
- Reset mid-load: i_rst=1 in WAIT_LOAD, then ack arrives after reset -> no write, all outputs 0, `o_stall`=0.

Source files
------------

// File: rtl/asrv32_writeback.sv
// Writeback stage for the asrv32 core: retires ALU results and aligned load data into the register file.
// Optional feature macro ASRV32_WB_FWD_EN adds a registered forwarding port for the decode-stage bypass.
module asrv32_writeback #(
    parameter int unsigned LOAD_TIMEOUT = 0,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_alu_result,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall,
    output logic        o_ce_wr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_load_fault
`ifdef ASRV32_WB_FWD_EN
    ,
    output logic        o_fwd_valid,
    output logic [4:0]  o_fwd_addr,
    output logic [31:0] o_fwd_data
`endif
);

    typedef enum logic {IDLE, WAIT_LOAD} state_e;

    localparam bit               TIMEOUT_EN   = (LOAD_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ce_wr_q, ce_wr_d;
    logic [4:0]        rd_addr_q;
    logic [31:0]       rd_data_q;
    logic              load_fault_q, load_fault_d;

    logic [4:0]        cap_rd_addr_q;
    logic              cap_wr_rd_q;
    logic [2:0]        cap_funct3_q;
    logic [1:0]        cap_lsb_q;
    logic              capture;

    logic              wr_fire;
    logic              wr_we;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;

    function automatic logic [31:0] align_load(input logic [2:0]  funct3,
                                               input logic [1:0]  lsb,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lsb, 3'b000} +: 8];
        h = lsb[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    assign o_stall = ((state_q == WAIT_LOAD) & ~i_mem_ack)
                   | ((state_q == IDLE) & i_ce & i_is_load & ~i_mem_ack);

    // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_fault_d = 1'b0;
        capture      = 1'b0;
        wr_fire      = 1'b0;
        wr_we        = i_wr_rd;
        wr_addr      = i_rd_addr;
        wr_data      = i_alu_result;
        case (state_q)
            IDLE: begin
                if (i_ce) begin
                    if (!i_is_load) begin
                        wr_fire = 1'b1;
                    end else if (i_mem_ack) begin
                        wr_fire = 1'b1;
                        wr_data = align_load(i_funct3, i_addr_lsb, i_mem_rdata);
                    end else begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                wr_we   = cap_wr_rd_q;
                wr_addr = cap_rd_addr_q;
                wr_data = align_load(cap_funct3_q, cap_lsb_q, i_mem_rdata);
                // Ack takes priority over a timeout landing in the same cycle.
                if (i_mem_ack) begin
                    wr_fire = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    load_fault_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ce_wr_d = wr_fire & wr_we & (wr_addr != 5'd0);
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ce_wr_q      <= 1'b0;
            rd_addr_q    <= 5'd0;
            rd_data_q    <= 32'd0;
            load_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ce_wr_q      <= ce_wr_d;
            load_fault_q <= load_fault_d;
            if (ce_wr_d) begin
                rd_addr_q <= wr_addr;
                rd_data_q <= wr_data;
            end
        end
    end

    // NOTE: captured load fields need no reset; they are only read in WAIT_LOAD, which reset exits.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            cap_rd_addr_q <= i_rd_addr;
            cap_wr_rd_q   <= i_wr_rd;
            cap_funct3_q  <= i_funct3;
            cap_lsb_q     <= i_addr_lsb;
        end
    end

    assign o_ce_wr      = ce_wr_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_rd_data    = rd_data_q;
    assign o_load_fault = load_fault_q;

`ifdef ASRV32_WB_FWD_EN
    assign o_fwd_valid = ce_wr_q;
    assign o_fwd_addr  = rd_addr_q;
    assign o_fwd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_asrv32_writeback.sv
// Directed self-checking bench for asrv32_writeback, built with LOAD_TIMEOUT=4.
module tb_asrv32_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        wr_rd;
    logic [4:0]  rd_addr;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  addr_lsb;
    logic [31:0] alu_result;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        ce_wr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        load_fault;
`ifdef ASRV32_WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    asrv32_writeback #(.LOAD_TIMEOUT(4), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ce         (ce),
        .i_wr_rd      (wr_rd),
        .i_rd_addr    (rd_addr),
        .i_is_load    (is_load),
        .i_funct3     (funct3),
        .i_addr_lsb   (addr_lsb),
        .i_alu_result (alu_result),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .o_stall      (stall),
        .o_ce_wr      (ce_wr),
        .o_rd_addr    (wr_addr),
        .o_rd_data    (wr_data),
        .o_load_fault (load_fault)
`ifdef ASRV32_WB_FWD_EN
        ,
        .o_fwd_valid  (fwd_valid),
        .o_fwd_addr   (fwd_addr),
        .o_fwd_data   (fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ce_e, input logic [4:0] addr_e,
                              input logic [31:0] data_e, input logic fault_e);
        check({tag, ".ce_wr"}, {31'd0, ce_wr}, {31'd0, ce_e});
        check({tag, ".addr"},  {27'd0, wr_addr}, {27'd0, addr_e});
        check({tag, ".data"},  wr_data, data_e);
        check({tag, ".fault"}, {31'd0, load_fault}, {31'd0, fault_e});
`ifdef ASRV32_WB_FWD_EN
        check({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, ce_e});
        check({tag, ".fwd_addr"},  {27'd0, fwd_addr}, {27'd0, addr_e});
        check({tag, ".fwd_data"},  fwd_data, data_e);
`endif
    endtask

    task automatic expect_stall(input string tag, input logic exp);
        #1;
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic load, input logic wr, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] alu,
                           input logic ack, input logic [31:0] rdata);
        ce         = 1'b1;
        is_load    = load;
        wr_rd      = wr;
        rd_addr    = rd;
        funct3     = f3;
        addr_lsb   = lsb;
        alu_result = alu;
        mem_ack    = ack;
        mem_rdata  = rdata;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; wr_rd = 1'b0; rd_addr = 5'd0; is_load = 1'b0;
        funct3 = 3'd0; addr_lsb = 2'd0; alu_result = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        expect_out("reset", 1'b0, 5'd0, 32'd0, 1'b0);
        expect_stall("reset", 1'b0);
        rst = 1'b0;
        tick();

        // ALU write with latency 1, then data hold
        present(1'b0, 1'b1, 5'd5, 3'd0, 2'd0, 32'h1234_5678, 1'b0, 32'd0);
        expect_stall("alu", 1'b0);
        tick();
        ce = 1'b0;
        expect_out("alu", 1'b1, 5'd5, 32'h1234_5678, 1'b0);
        tick();
        expect_out("alu_hold", 1'b0, 5'd5, 32'h1234_5678, 1'b0);

        // x0 suppression for ALU and loads, and wr_rd=0
        present(1'b0, 1'b1, 5'd0, 3'd0, 2'd0, 32'hFFFF_FFFF, 1'b0, 32'd0);
        tick();
        expect_out("x0_alu", 1'b0, 5'd5, 32'h1234_5678, 1'b0);
        present(1'b1, 1'b1, 5'd0, 3'b010, 2'd0, 32'd0, 1'b1, 32'hCAFE_F00D);
        expect_stall("x0_load", 1'b0);
        tick();
        expect_out("x0_load", 1'b0, 5'd5, 32'h1234_5678, 1'b0);
        present(1'b0, 1'b0, 5'd6, 3'd0, 2'd0, 32'h0BAD_0BAD, 1'b0, 32'd0);
        tick();
        ce = 1'b0;
        expect_out("no_wr_rd", 1'b0, 5'd5, 32'h1234_5678, 1'b0);

        // same-cycle-ack loads, back to back
        present(1'b1, 1'b1, 5'd7, 3'b000, 2'd3, 32'd0, 1'b1, 32'h80FF_0000);
        expect_stall("lb", 1'b0);
        tick();
        expect_out("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
        present(1'b1, 1'b1, 5'd7, 3'b100, 2'd3, 32'd0, 1'b1, 32'h80FF_0000);
        tick();
        expect_out("lbu", 1'b1, 5'd7, 32'h0000_0080, 1'b0);
        present(1'b1, 1'b1, 5'd7, 3'b001, 2'd2, 32'd0, 1'b1, 32'h80FF_0000);
        tick();
        expect_out("lh", 1'b1, 5'd7, 32'hFFFF_80FF, 1'b0);
        present(1'b1, 1'b1, 5'd8, 3'b101, 2'd3, 32'd0, 1'b1, 32'h80FF_0000);
        tick();
        expect_out("lhu", 1'b1, 5'd8, 32'h0000_80FF, 1'b0);
        present(1'b1, 1'b1, 5'd8, 3'b010, 2'd3, 32'd0, 1'b1, 32'h8765_4321);
        tick();
        expect_out("lw", 1'b1, 5'd8, 32'h8765_4321, 1'b0);

        // back-to-back ALU throughput
        present(1'b0, 1'b1, 5'd1, 3'd0, 2'd0, 32'h0000_0011, 1'b0, 32'd0);
        tick();
        expect_out("b2b_1", 1'b1, 5'd1, 32'h0000_0011, 1'b0);
        present(1'b0, 1'b1, 5'd2, 3'd0, 2'd0, 32'h0000_0022, 1'b0, 32'd0);
        tick();
        expect_out("b2b_2", 1'b1, 5'd2, 32'h0000_0022, 1'b0);

        // stalled load: three cycles without ack, then ack
        present(1'b1, 1'b1, 5'd9, 3'b010, 2'd0, 32'd0, 1'b0, 32'd0);
        expect_stall("stl_c0", 1'b1);
        tick();
        expect_out("stl_c1", 1'b0, 5'd2, 32'h0000_0022, 1'b0);
        expect_stall("stl_c1", 1'b1);
        tick();
        expect_out("stl_c2", 1'b0, 5'd2, 32'h0000_0022, 1'b0);
        expect_stall("stl_c2", 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        expect_stall("stl_ack", 1'b0);
        tick();
        ce = 1'b0; mem_ack = 1'b0;
        expect_out("stl_wr", 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0);
        tick();
        expect_out("stl_after", 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b0);

        // timeout: present + four WAIT_LOAD cycles, then fault pulse
        present(1'b1, 1'b1, 5'd10, 3'b010, 2'd0, 32'd0, 1'b0, 32'd0);
        expect_stall("to_req", 1'b1);
        tick();
        ce = 1'b0;
        tick(); tick(); tick();
        expect_stall("to_last", 1'b1);
        expect_out("to_last", 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b0);
        tick();
        expect_out("to_fault", 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b1);
        expect_stall("to_fault", 1'b0);
        tick();
        expect_out("to_after", 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b0);

        // ack on the final cycle wins over timeout; captured fields are used
        present(1'b1, 1'b1, 5'd12, 3'b100, 2'd1, 32'd0, 1'b0, 32'd0);
        tick();
        ce = 1'b0; rd_addr = 5'd3; funct3 = 3'b010; addr_lsb = 2'd0;
        tick(); tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_A500;
        expect_stall("ack_last", 1'b0);
        tick();
        mem_ack = 1'b0;
        expect_out("ack_last", 1'b1, 5'd12, 32'h0000_00A5, 1'b0);

        // reset mid-load abandons it; a later ack in IDLE is ignored
        present(1'b1, 1'b1, 5'd13, 3'b010, 2'd0, 32'd0, 1'b0, 32'd0);
        tick();
        ce = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        expect_stall("rst_mid", 1'b0);
        expect_out("rst_mid", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        expect_out("rst_ack", 1'b0, 5'd0, 32'd0, 1'b0);
        mem_ack = 1'b0;
        tick();
        expect_out("rst_end", 1'b0, 5'd0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
